// File: rtl/soc2_nios_oci_dct_packer.sv
// Packs 2-bit compressed trace atoms into 30-bit frames and hands them to a
// consumer through a single output register with ready/valid backpressure.
module soc2_nios_oci_dct_packer #(
  parameter int MAX_ATOMS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_enable,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  input  logic        flush,
  input  logic        frame_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  output logic        overflow,
  output logic        test_ending,
  output logic        test_has_ended
);

  localparam logic [3:0] MAX_C = 4'(MAX_ATOMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        fv_q, fv_d;
  logic        ovf_q, ovf_d;
  logic        ending_q, ending_d;
  logic        ended_q, ended_d;

  logic        enter_run;
  logic        full;
  logic        trigger;
  logic        xfer;
  logic        atom_ok;
  logic        accept;
  logic        drop;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    buf_d     = buf_q;
    dcnt_d    = dcnt_q;
    fv_d      = fv_q;
    ovf_d     = ovf_q;

    enter_run = ((state_q == IDLE) || (state_q == ENDED)) && trace_enable;

    unique case (state_q)
      IDLE:    if (trace_enable) state_d = RUN;
      RUN:     if (!trace_enable) state_d = DRAIN;
      DRAIN:   if ((cnt_q == 4'd0) && !fv_q) state_d = ENDED;
      ENDED:   if (trace_enable) state_d = RUN;
      default: state_d = IDLE;
    endcase

    full    = (cnt_q == MAX_C);
    trigger = full || pend_q || ((state_q == DRAIN) && (cnt_q != 4'd0));
    xfer    = trigger && (!fv_q || frame_ready);
    atom_ok = (state_q == RUN) && atom_valid && (atom != 2'b00);
    // A full accumulator still accepts when it empties on this same edge.
    accept  = atom_ok && (!full || xfer);
    drop    = atom_ok && full && !xfer;

    if (xfer) begin
      buf_d  = acc_q;
      dcnt_d = cnt_q;
      fv_d   = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (frame_ready) begin
      fv_d = 1'b0;
    end

    if (accept) begin
      acc_d = acc_d | (30'(atom) << {cnt_d, 1'b0});
      cnt_d = cnt_d + 4'd1;
    end

    pend_d = (pend_q || (flush && (state_q == RUN))) && !xfer && (cnt_q != 4'd0);
    ovf_d  = ovf_q || drop;

    if (enter_run) begin
      acc_d  = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end

    ending_d = (state_d == DRAIN);
    ended_d  = (state_d == ENDED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      buf_q    <= '0;
      dcnt_q   <= '0;
      fv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      buf_q    <= buf_d;
      dcnt_q   <= dcnt_d;
      fv_q     <= fv_d;
      ovf_q    <= ovf_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = dcnt_q;
  assign frame_valid    = fv_q;
  assign overflow       = ovf_q;
  assign test_ending    = ending_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_soc2_nios_oci_dct_packer.sv
// Directed bench for the DCT atom packer: full frames, flush, backpressure,
// drain sequence and asynchronous reset.
module tb_soc2_nios_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic        overflow;
  logic        test_ending;
  logic        test_has_ended;

  int n_cmp = 0;
  int n_mis = 0;

  soc2_nios_oci_dct_packer #(.MAX_ATOMS(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .trace_enable  (trace_enable),
    .atom_valid    (atom_valid),
    .atom          (atom),
    .flush         (flush),
    .frame_ready   (frame_ready),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .frame_valid   (frame_valid),
    .overflow      (overflow),
    .test_ending   (test_ending),
    .test_has_ended(test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_fv"},    32'(frame_valid),    32'd0);
    check_eq({tag, "_cnt"},   32'(dct_count),      32'd0);
    check_eq({tag, "_buf"},   32'(dct_buffer),     32'd0);
    check_eq({tag, "_ovf"},   32'(overflow),       32'd0);
    check_eq({tag, "_end"},   32'(test_ending),    32'd0);
    check_eq({tag, "_ended"}, 32'(test_has_ended), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    trace_enable = 1'b0;
    atom_valid   = 1'b0;
    atom         = 2'b00;
    flush        = 1'b0;
    frame_ready  = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Full frame of 15 x 01 with the consumer always ready
    trace_enable = 1'b1;
    frame_ready  = 1'b1;
    tick();
    atom_valid = 1'b1;
    atom       = 2'b01;
    repeat (15) tick();
    atom_valid = 1'b0;
    check_eq("full_latency_fv", 32'(frame_valid), 32'd0);
    tick();
    check_eq("full_fv",  32'(frame_valid), 32'd1);
    check_eq("full_cnt", 32'(dct_count),   32'd15);
    check_eq("full_buf", 32'(dct_buffer),  32'h15555555);
    check_eq("full_ovf", 32'(overflow),    32'd0);
    tick();
    check_eq("full_fv_clear", 32'(frame_valid), 32'd0);

    // Partial frame via flush: 10, 11, 01
    atom_valid = 1'b1;
    atom = 2'b10; tick();
    atom = 2'b11; tick();
    atom = 2'b01; tick();
    atom_valid = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0;
    check_eq("flush_fv_pre", 32'(frame_valid), 32'd0);
    tick();
    check_eq("flush_fv",  32'(frame_valid), 32'd1);
    check_eq("flush_cnt", 32'(dct_count),   32'd3);
    check_eq("flush_buf", 32'(dct_buffer),  32'h0000001E);
    tick();
    check_eq("flush_fv_clear", 32'(frame_valid), 32'd0);

    // Flush with an empty accumulator yields no frame
    flush = 1'b1; tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("empty_flush_fv", 32'(frame_valid), 32'd0);
      tick();
    end

    // Atom landing on the transfer edge, then a reserved atom
    atom_valid = 1'b1;
    atom       = 2'b01;
    repeat (15) tick();
    atom = 2'b10;
    tick();
    check_eq("simul_fv",  32'(frame_valid), 32'd1);
    check_eq("simul_cnt", 32'(dct_count),   32'd15);
    check_eq("simul_buf", 32'(dct_buffer),  32'h15555555);
    atom = 2'b00;
    tick();
    atom_valid = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0;
    tick();
    check_eq("simul_slot0_fv",  32'(frame_valid), 32'd1);
    check_eq("simul_slot0_cnt", 32'(dct_count),   32'd1);
    check_eq("simul_slot0_buf", 32'(dct_buffer),  32'h00000002);
    check_eq("simul_ovf",       32'(overflow),    32'd0);
    tick();

    // Backpressure: 31 atoms of 11 with the consumer stalled
    frame_ready = 1'b0;
    atom_valid  = 1'b1;
    atom        = 2'b11;
    repeat (16) tick();
    check_eq("bp_first_fv",  32'(frame_valid), 32'd1);
    check_eq("bp_first_cnt", 32'(dct_count),   32'd15);
    repeat (14) tick();
    check_eq("bp_hold_buf", 32'(dct_buffer), 32'h3FFFFFFF);
    check_eq("bp_hold_cnt", 32'(dct_count),  32'd15);
    check_eq("bp_ovf_30",   32'(overflow),   32'd0);
    tick();
    atom_valid = 1'b0;
    check_eq("bp_ovf_31", 32'(overflow),    32'd1);
    check_eq("bp_fv_31",  32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    tick();
    check_eq("bp_second_fv",  32'(frame_valid), 32'd1);
    check_eq("bp_second_cnt", 32'(dct_count),   32'd15);
    check_eq("bp_second_buf", 32'(dct_buffer),  32'h3FFFFFFF);
    tick();
    check_eq("bp_done_fv",  32'(frame_valid), 32'd0);
    check_eq("bp_ovf_sticky", 32'(overflow),  32'd1);

    // Drain with four atoms outstanding
    atom_valid = 1'b1;
    atom       = 2'b01;
    repeat (4) tick();
    atom_valid   = 1'b0;
    trace_enable = 1'b0;
    tick();
    check_eq("drain_ending", 32'(test_ending), 32'd1);
    check_eq("drain_fv_pre", 32'(frame_valid), 32'd0);
    tick();
    check_eq("drain_fv",  32'(frame_valid), 32'd1);
    check_eq("drain_cnt", 32'(dct_count),   32'd4);
    check_eq("drain_buf", 32'(dct_buffer),  32'h00000055);
    tick();
    check_eq("drain_ending2", 32'(test_ending),    32'd1);
    check_eq("drain_ended0",  32'(test_has_ended), 32'd0);
    tick();
    check_eq("ended_ending", 32'(test_ending),    32'd0);
    check_eq("ended_ended",  32'(test_has_ended), 32'd1);
    check_eq("ended_ovf",    32'(overflow),       32'd1);
    trace_enable = 1'b1;
    tick();
    check_eq("rerun_ovf",   32'(overflow),       32'd0);
    check_eq("rerun_ended", 32'(test_has_ended), 32'd0);

    // Asynchronous reset while a frame is held
    frame_ready = 1'b0;
    atom_valid  = 1'b1;
    atom        = 2'b11;
    tick();
    atom_valid = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0;
    tick();
    check_eq("ar_pre_fv", 32'(frame_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    trace_enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_eq("ar_idle_ending", 32'(test_ending), 32'd0);
    check_eq("ar_idle_fv",     32'(frame_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
